// File: rtl/byte_stuffer.sv
// Byte stuffer for an entropy-coded image stream.
// Pops 33-bit words ({last, 4 bytes MSB first}) from a first-word-fall-through FIFO and
// emits them one byte per cycle over a valid/ready link. Every emitted FF is followed by
// a stuffed 00. After a last-flagged word it optionally appends the FF D9 end marker,
// then pulses frame_done_o for one cycle.
//
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous active-high reset
//   fifo_empty_i    upstream FIFO empty flag
//   fifo_rd_data_i  FIFO head word: [32] last-of-frame, [31:0] four bytes, MSB first
//   fifo_rd_o       combinational pop request
//   out_valid_o     out_byte_o is valid
//   out_ready_i     downstream accepts out_byte_o this cycle
//   out_byte_o      output byte (00 when not valid)
//   frame_done_o    one-cycle pulse after the final byte of a frame
//   byte_cnt_o      bytes handed off in the current frame, stuffing and marker included
module byte_stuffer #(
  parameter bit          EOI_EN    = 1'b1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty_i,
  input  logic [32:0]          fifo_rd_data_i,
  output logic                 fifo_rd_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [7:0]           out_byte_o,
  output logic                 frame_done_o,
  output logic [CNT_WIDTH-1:0] byte_cnt_o
);

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StStuff,
    StEoiFf,
    StEoiD9,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [31:0]          word_q, word_d;
  logic                 last_q, last_d;
  logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;

  logic       fifo_rd;
  logic       hs;
  logic       advance;
  logic [7:0] cur_byte;

  always_comb begin
    unique case (idx_q)
      2'd0:    cur_byte = word_q[31:24];
      2'd1:    cur_byte = word_q[23:16];
      2'd2:    cur_byte = word_q[15:8];
      default: cur_byte = word_q[7:0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    word_d       = word_q;
    last_d       = last_q;
    byte_cnt_d   = byte_cnt_q;
    fifo_rd      = 1'b0;
    out_valid_o  = 1'b0;
    out_byte_o   = 8'h00;
    frame_done_o = 1'b0;
    advance      = 1'b0;

    unique case (state_q)
      StIdle: begin
        fifo_rd = ~fifo_empty_i;
        if (!fifo_empty_i) begin
          word_d  = fifo_rd_data_i[31:0];
          last_d  = fifo_rd_data_i[32];
          idx_d   = 2'd0;
          state_d = StSend;
        end
      end
      StSend: begin
        out_valid_o = 1'b1;
        out_byte_o  = cur_byte;
      end
      StStuff: begin
        out_valid_o = 1'b1;
        out_byte_o  = 8'h00;
      end
      StEoiFf: begin
        out_valid_o = 1'b1;
        out_byte_o  = 8'hFF;
      end
      StEoiD9: begin
        out_valid_o = 1'b1;
        out_byte_o  = 8'hD9;
      end
      StDone: begin
        frame_done_o = 1'b1;
        byte_cnt_d   = '0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    hs = out_valid_o & out_ready_i;

    if (hs) begin
      byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
      unique case (state_q)
        StSend: begin
          if (cur_byte == 8'hFF) state_d = StStuff;
          else                   advance = 1'b1;
        end
        StStuff: advance = 1'b1;
        StEoiFf: state_d = StEoiD9;
        StEoiD9: state_d = StDone;
        default: ;
      endcase
    end

    if (advance) begin
      if (idx_q != 2'd3) begin
        idx_d   = idx_q + 2'd1;
        state_d = StSend;
      end else if (!last_q) begin
        // Chain straight into the next word so words stream without a bubble.
        if (!fifo_empty_i) begin
          fifo_rd = 1'b1;
          word_d  = fifo_rd_data_i[31:0];
          last_d  = fifo_rd_data_i[32];
          idx_d   = 2'd0;
          state_d = StSend;
        end else begin
          state_d = StIdle;
        end
      end else begin
        state_d = EOI_EN ? StEoiFf : StDone;
      end
    end
  end

  // The pop strobe is combinational, so it must be masked while reset is held.
  assign fifo_rd_o  = fifo_rd & ~rst;
  assign byte_cnt_o = byte_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      word_q     <= 32'h0;
      last_q     <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      last_q     <= last_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: tb/tb_byte_stuffer.sv
// Directed bench for byte_stuffer: a FIFO model feeds one of two instances (marker on / off);
// captured bytes, pops, stalls and frame_done pulses are compared with hand-computed values.
module tb_byte_stuffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_ready;
  logic [32:0] fifo_data;
  logic        fe_a, fe_b;
  logic        rd_a, rd_b, ov_a, ov_b, fd_a, fd_b;
  logic [7:0]  ob_a, ob_b;
  logic [15:0] bc_a, bc_b;

  always #5 clk = ~clk;

  byte_stuffer #(.EOI_EN(1'b1), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty_i   (fe_a),
    .fifo_rd_data_i (fifo_data),
    .fifo_rd_o      (rd_a),
    .out_valid_o    (ov_a),
    .out_ready_i    (out_ready),
    .out_byte_o     (ob_a),
    .frame_done_o   (fd_a),
    .byte_cnt_o     (bc_a)
  );

  byte_stuffer #(.EOI_EN(1'b0), .CNT_WIDTH(16)) dut_ne (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty_i   (fe_b),
    .fifo_rd_data_i (fifo_data),
    .fifo_rd_o      (rd_b),
    .out_valid_o    (ov_b),
    .out_ready_i    (out_ready),
    .out_byte_o     (ob_b),
    .frame_done_o   (fd_b),
    .byte_cnt_o     (bc_b)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [32:0] fq[$];
  logic [7:0]  got[$];
  int cyc, first_v, last_v, n_valid, rd_cnt, rd_err, zero_err, stall_err, fd_cnt, fd_bcnt;
  bit prev_stall;
  logic [7:0] prev_byte;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    got.delete();
    cyc = 0; first_v = -1; last_v = -1; n_valid = 0; rd_cnt = 0; rd_err = 0;
    zero_err = 0; stall_err = 0; fd_cnt = 0; fd_bcnt = -1; prev_stall = 1'b0;
    prev_byte = 8'h00;
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, pop on the rising edge.
  task automatic cycle(input bit sel, input bit rdy);
    bit fe, v, rd, fd;
    logic [7:0] b;
    logic [15:0] bc;
    out_ready = rdy;
    fe        = (fq.size() == 0);
    fifo_data = fe ? 33'h0 : fq[0];
    fe_a      = sel ? 1'b1 : fe;
    fe_b      = sel ? fe : 1'b1;
    #1;
    v  = sel ? ov_b : ov_a;
    b  = sel ? ob_b : ob_a;
    rd = sel ? rd_b : rd_a;
    fd = sel ? fd_b : fd_a;
    bc = sel ? bc_b : bc_a;
    if (rd && fe) rd_err++;
    if (rd) rd_cnt++;
    if (!v && b != 8'h00) zero_err++;
    if (prev_stall && (!v || b != prev_byte)) stall_err++;
    prev_stall = v && !rdy;
    prev_byte  = b;
    if (v && rdy) begin
      got.push_back(b);
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      n_valid++;
    end
    if (fd) begin
      fd_cnt++;
      fd_bcnt = int'(bc);
    end
    cyc++;
    @(posedge clk);
    if (rd && !fe) void'(fq.pop_front());
    @(negedge clk);
  endtask

  task automatic run(input bit sel, input int mode, input int n);
    // mode 0: always ready, mode 1: ready toggles every cycle
    for (int i = 0; i < n; i++) cycle(sel, (mode == 0) ? 1'b1 : i[0]);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
    check_eq({tag, " len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) check_eq($sformatf("%s b%0d", tag, i), {24'h0, got[i]}, {24'h0, exp[i]});
    end
  endtask

  task automatic check_common(input string tag, input int exp_fd, input int exp_bc);
    check_eq({tag, " frame_done"}, fd_cnt, exp_fd);
    if (exp_fd > 0) check_eq({tag, " byte_cnt"}, fd_bcnt, exp_bc);
    check_eq({tag, " rd_empty"}, rd_err, 0);
    check_eq({tag, " zero_byte"}, zero_err, 0);
    check_eq({tag, " stall"}, stall_err, 0);
  endtask

  initial begin
    logic [7:0] exp[$];
    rst = 1'b1; out_ready = 1'b0; fifo_data = 33'h0; fe_a = 1'b0; fe_b = 1'b0;
    #1;
    // Reset state, with a non-empty FIFO presented: no pop allowed.
    check_eq("rst valid", ov_a, 1'b0);
    check_eq("rst byte", ob_a, 8'h00);
    check_eq("rst fd", fd_a, 1'b0);
    check_eq("rst cnt", bc_a, 16'h0);
    check_eq("rst rd", rd_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    fe_a = 1'b1; fe_b = 1'b1;
    @(negedge clk);

    // Single-word frame with marker.
    clear_stats();
    fq.push_back({1'b1, 32'h12345678});
    run(0, 0, 12);
    exp = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hD9};
    check_bytes("f1", exp);
    check_common("f1", 1, 6);
    check_eq("f1 consecutive", last_v - first_v + 1, n_valid);

    // Two words with stuffing, chained without a bubble.
    clear_stats();
    fq.push_back({1'b0, 32'hFF00FFAB});
    fq.push_back({1'b1, 32'h01020304});
    run(0, 0, 20);
    exp = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hAB, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hD9};
    check_bytes("f2", exp);
    check_common("f2", 1, 12);
    check_eq("f2 pops", rd_cnt, 2);
    check_eq("f2 no bubble", last_v - first_v + 1, n_valid);

    // Backpressure: ready toggles every cycle.
    clear_stats();
    fq.push_back({1'b1, 32'hAABBCCDD});
    run(0, 1, 24);
    exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 8'hD9};
    check_bytes("f3", exp);
    check_common("f3", 1, 6);

    // FIFO underrun after a non-last word, then resume.
    clear_stats();
    fq.push_back({1'b0, 32'h11223344});
    run(0, 0, 10);
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_bytes("f4a", exp);
    check_eq("f4a frame_done", fd_cnt, 0);
    check_eq("f4a idle valid", ov_a, 1'b0);
    check_eq("f4a idle rd", rd_a, 1'b0);
    clear_stats();
    fq.push_back({1'b1, 32'h55667788});
    run(0, 0, 12);
    exp = '{8'h55, 8'h66, 8'h77, 8'h88, 8'hFF, 8'hD9};
    check_bytes("f4b", exp);
    check_common("f4b", 1, 10);

    // Reset mid-word, then a fresh frame.
    clear_stats();
    fq.push_back({1'b1, 32'hAABB1122});
    run(0, 0, 3);
    check_eq("f5 pre valid", ov_a, 1'b1);
    fq.push_back({1'b1, 32'h00000000});
    fe_a = 1'b0; fifo_data = fq[0]; out_ready = 1'b1;
    rst = 1'b1;
    #1;
    check_eq("f5 rst valid", ov_a, 1'b0);
    check_eq("f5 rst byte", ob_a, 8'h00);
    check_eq("f5 rst cnt", bc_a, 16'h0);
    check_eq("f5 rst rd", rd_a, 1'b0);
    check_eq("f5 rst fd", fd_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    run(0, 0, 12);
    exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hD9};
    check_bytes("f5", exp);
    check_common("f5", 1, 6);

    // Marker disabled.
    clear_stats();
    fq.push_back({1'b1, 32'hFFFFFFFF});
    run(1, 0, 14);
    exp = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    check_bytes("f6", exp);
    check_common("f6", 1, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/byte_stuffer.md
BYTE_STUFFER -- requirements
Module: byte_stuffer

Interface
REQ-001 Parameter EOI_EN, default 1: 1 appends the EOI marker FF D9 after a last-flagged word; 0 suppresses it.
REQ-002 Parameter CNT_WIDTH, default 16: width of byte_cnt.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 fifo_rd_data  input  33  FIFO head word: [32] last-of-frame, [31:0] four entropy-coded bytes, MSB byte first.
REQ-007 fifo_rd  output  1  pop request to the FIFO; combinational.
REQ-008 out_valid  output  1  out_byte is valid.
REQ-009 out_ready  input  1  downstream accepts out_byte this cycle.
REQ-010 out_byte  output  8  output byte stream.
REQ-011 frame_done  output  1  one-cycle pulse after the final byte of a frame.
REQ-012 byte_cnt  output  CNT_WIDTH  bytes emitted in the current frame.

Function
REQ-013 The FIFO contract is first-word-fall-through: while fifo_empty=0, fifo_rd_data is the head word, and a cycle with fifo_rd=1 pops it; the next head is valid in the following cycle.
REQ-014 fifo_rd shall never be asserted while fifo_empty=1.
REQ-015 The state machine shall have states IDLE, SEND, STUFF, EOI_FF, EOI_D9 and DONE.
REQ-016 IDLE: out_valid=0; fifo_rd=~fifo_empty. On a pop, the edge captures fifo_rd_data into the word/last registers, sets byte index idx=0 and enters SEND.
REQ-017 SEND: out_valid=1; out_byte=word[31-8*idx -: 8].
REQ-018 A handshake is out_valid & out_ready in the same cycle; out_byte and state are held unchanged while out_valid=1 and out_ready=0.
REQ-019 SEND handshake with out_byte=8'hFF: go to STUFF with idx unchanged.
REQ-020 SEND handshake with out_byte!=8'hFF: apply the advance rule.
REQ-021 STUFF: out_valid=1, out_byte=8'h00; on handshake, apply the advance rule.
REQ-022 Advance rule, idx<3: idx increments and the state goes to SEND.
REQ-023 Advance rule, idx=3 and last=0: if fifo_empty=0, assert fifo_rd in the same cycle, load the new word, set idx=0 and stay in SEND with no bubble; otherwise go to IDLE.
REQ-024 Advance rule, idx=3 and last=1: go to EOI_FF if EOI_EN=1, else to DONE.
REQ-025 EOI_FF: out_valid=1, out_byte=8'hFF with no stuffing; go to EOI_D9 on handshake.
REQ-026 EOI_D9: out_valid=1, out_byte=8'hD9; go to DONE on handshake.
REQ-027 DONE: out_valid=0, fifo_rd=0, frame_done=1 for exactly one cycle, then IDLE.
REQ-028 byte_cnt increments by 1 on every handshake, including stuffed 00 bytes and EOI bytes, and wraps modulo 2^CNT_WIDTH.
REQ-029 byte_cnt holds the frame total during the DONE cycle and clears to 0 on the edge leaving DONE.
REQ-030 out_byte shall be 8'h00 whenever out_valid=0.
REQ-031 Throughput: one byte per cycle while out_ready=1 and the FIFO is non-empty at word boundaries.

Reset
REQ-032 Asserting rst forces, immediately and asynchronously: state=IDLE, idx=0, word=0, last=0, out_valid=0, out_byte=8'h00, frame_done=0, byte_cnt=0.
REQ-033 fifo_rd=0 while rst=1.
REQ-034 A reset mid-frame discards the held word with no EOI and no frame_done; after release the block restarts in IDLE.

Verification
REQ-035 Push {1,32'h12345678}, out_ready=1 -> bytes 12 34 56 78 FF D9 on consecutive cycles; frame_done pulse with byte_cnt=6.
REQ-036 Push {0,32'hFF00FFAB} then {1,32'h01020304} -> FF 00 00 FF 00 AB 01 02 03 04 FF D9; single fifo_rd per word; no bubble between words; byte_cnt=12.
REQ-037 out_ready toggled 0/1 every cycle on {1,32'hAABBCCDD} -> out_byte stable while stalled; exactly AA BB CC DD FF D9 delivered.
REQ-038 FIFO empties after a non-last word -> IDLE with out_valid=0 and fifo_rd=0; resumes on the next push; no frame_done until the last word.
REQ-039 rst asserted after the second byte of a word -> all outputs reset in the same cycle; a following frame {1,32'h0} gives 00 00 00 00 FF D9, byte_cnt=6.
REQ-040 EOI_EN=0 with {1,32'hFFFFFFFF} -> FF 00 FF 00 FF 00 FF 00, then frame_done with byte_cnt=8.
